// File: rtl/fe_pkg.sv
// Shared types and constants for the audio front-end source sequencer and its
// sample-rate divider.
package fe_pkg;

    localparam int FE_DIV_W = 11;

    typedef enum logic [1:0] {
        SRC_PCM   = 2'd0,
        SRC_POSDC = 2'd1,
        SRC_NEGDC = 2'd2,
        SRC_TRI   = 2'd3
    } src_sel_e;

    typedef enum logic [2:0] {
        RATE_44K1 = 3'd0,
        RATE_48K  = 3'd1,
        RATE_88K2 = 3'd2,
        RATE_96K  = 3'd3,
        RATE_192K = 3'd4
    } rate_code_e;

    // Divider terminal counts for a 49.152 MHz mclk; period is terminal+1 clks.
    localparam logic [FE_DIV_W-1:0] DIV_TERM_44K1   = 11'h45A;
    localparam logic [FE_DIV_W-1:0] DIV_TERM_48K    = 11'h3FF;
    localparam logic [FE_DIV_W-1:0] DIV_TERM_88K2   = 11'h22C;
    localparam logic [FE_DIV_W-1:0] DIV_TERM_96K    = 11'h1FF;
    localparam logic [FE_DIV_W-1:0] DIV_TERM_192K   = 11'h0FF;
    localparam logic [FE_DIV_W-1:0] DIV_TERM_DEFAULT = 11'h3FF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        MUTE   = 3'd2,
        SWITCH = 3'd3,
        SETTLE = 3'd4
    } fe_state_e;

    function automatic logic [FE_DIV_W-1:0] rate_terminal(input logic [2:0] rate);
        case (rate)
            RATE_44K1: rate_terminal = DIV_TERM_44K1;
            RATE_48K:  rate_terminal = DIV_TERM_48K;
            RATE_88K2: rate_terminal = DIV_TERM_88K2;
            RATE_96K:  rate_terminal = DIV_TERM_96K;
            RATE_192K: rate_terminal = DIV_TERM_192K;
            default:   rate_terminal = DIV_TERM_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/fe_smp_divider.sv
// Sample-rate divider: counts 0..terminal and emits a registered one-clk strobe
// on the clk following the terminal count.
module fe_smp_divider
    import fe_pkg::*;
#(
    parameter int DIV_W = FE_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] terminal,
    input  logic             clear,
    input  logic             enable,
    output logic [DIV_W-1:0] count,
    output logic             strobe
);

    logic [DIV_W-1:0] count_q, count_d;
    logic             strobe_q, strobe_d;

    always_comb begin
        count_d  = count_q;
        strobe_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            // >= so a terminal that shrinks under a running count still wraps
            if (count_q >= terminal) begin
                count_d  = '0;
                strobe_d = 1'b1;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            strobe_q <= strobe_d;
        end
    end

    assign count  = count_q;
    assign strobe = strobe_q;

endmodule

// File: rtl/fe_source_sequencer.sv
// Front-end source/rate sequencer: every SW change of source or rate is applied
// under mute (mute, switch, settle, unmute), paced by the sample strobe.
//
// state  | meaning
// IDLE   | run low; divider held at 0, muted
// RUN    | active source playing, unmuted
// MUTE   | muted, waiting MUTE_SMPS strobes before switching
// SWITCH | one clk: latch requests, restart divider
// SETTLE | muted, waiting SETTLE_SMPS strobes before unmuting
module fe_source_sequencer
    import fe_pkg::*;
#(
    parameter int MUTE_SMPS   = 4,
    parameter int SETTLE_SMPS = 8,
    parameter int DIV_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       req_select,
    input  logic [2:0]       req_rate,
    output logic             smp_strobe,
    output logic [1:0]       src_select,
    output logic [2:0]       rate_active,
    output logic             mute,
    output logic             busy,
    output logic [DIV_W-1:0] smp_count
);

    localparam logic [7:0] MUTE_LAST   = 8'(MUTE_SMPS - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SMPS - 1);

    fe_state_e        state_q, state_d;
    logic [1:0]       src_q, src_d;
    logic [2:0]       rate_q, rate_d;
    logic [7:0]       scnt_q, scnt_d;
    logic             req_diff;
    logic             div_clear;
    logic             div_enable;
    logic [DIV_W-1:0] div_terminal;

    assign req_diff = (req_select != src_q) || (req_rate != rate_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        rate_d  = rate_q;
        case (state_q)
            IDLE: begin
                state_d = SETTLE;
                src_d   = req_select;
                rate_d  = req_rate;
            end
            RUN: begin
                if (req_diff) state_d = MUTE;
            end
            MUTE: begin
                if (smp_strobe && scnt_q == MUTE_LAST) state_d = SWITCH;
            end
            SWITCH: begin
                state_d = SETTLE;
                src_d   = req_select;
                rate_d  = req_rate;
            end
            SETTLE: begin
                // Already muted, so a late request change skips straight to SWITCH
                if (smp_strobe && scnt_q == SETTLE_LAST) state_d = req_diff ? SWITCH : RUN;
            end
            default: state_d = IDLE;
        endcase
        if (!run) begin
            state_d = IDLE;
            src_d   = src_q;
            rate_d  = rate_q;
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        if (state_d != state_q) begin
            scnt_d = '0;
        end else if (smp_strobe && busy) begin
            scnt_d = scnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= SRC_PCM;
            rate_q  <= RATE_48K;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            rate_q  <= rate_d;
            scnt_q  <= scnt_d;
        end
    end

    // Clearing on entry keeps both the count and the strobe at zero through SWITCH/IDLE
    assign div_clear    = (state_d == IDLE) || (state_d == SWITCH);
    assign div_enable   = (state_q != IDLE);
    assign div_terminal = DIV_W'(rate_terminal(rate_q));

    fe_smp_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .terminal (div_terminal),
        .clear    (div_clear),
        .enable   (div_enable),
        .count    (smp_count),
        .strobe   (smp_strobe)
    );

    assign src_select  = src_q;
    assign rate_active = rate_q;
    assign mute        = (state_q != RUN);
    assign busy        = (state_q == MUTE) || (state_q == SWITCH) || (state_q == SETTLE);

endmodule

// File: tb/tb_fe_source_sequencer.sv
// Scoreboard bench for fe_source_sequencer: expected strobe periods, switch
// events and muted-window strobe counts are queued with stimulus and retired by a monitor.
module tb_fe_source_sequencer;

    typedef struct {
        int src;
        int rate;
        int nstr;
        int cnt;
    } sw_exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [1:0]  req_select;
    logic [2:0]  req_rate;
    logic        smp_strobe;
    logic [1:0]  src_select;
    logic [2:0]  rate_active;
    logic        mute;
    logic        busy;
    logic [10:0] smp_count;

    int n_chk  = 0;
    int n_pass = 0;

    int      exp_period[$];
    int      exp_mute[$];
    sw_exp_t exp_sw[$];

    int         cyc         = 0;
    int         last_strobe = -1;
    int         win_strobes = 0;
    logic [1:0] prev_src;
    logic [2:0] prev_rate;
    logic       prev_mute;
    sw_exp_t    mon_e;

    fe_source_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .req_select  (req_select),
        .req_rate    (req_rate),
        .smp_strobe  (smp_strobe),
        .src_select  (src_select),
        .rate_active (rate_active),
        .mute        (mute),
        .busy        (busy),
        .smp_count   (smp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push_periods(input int val, input int n);
        for (int i = 0; i < n; i++) exp_period.push_back(val);
    endtask

    task automatic push_sw(input int src, input int rate, input int nstr, input int cnt);
        sw_exp_t e;
        e.src  = src;
        e.rate = rate;
        e.nstr = nstr;
        e.cnt  = cnt;
        exp_sw.push_back(e);
    endtask

    task automatic wait_mute_fall(input string tag, input int bound);
        int seen;
        seen = 0;
        for (int i = 0; i < bound && seen == 0; i++) begin
            @(negedge clk);
            if (!mute) seen = 1;
        end
        chk(tag, seen, 1);
    endtask

    // Monitor: retires scoreboard entries as the DUT produces strobes, switches and unmutes
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            last_strobe = -1;
            win_strobes = 0;
            prev_src    = src_select;
            prev_rate   = rate_active;
            prev_mute   = mute;
        end else begin
            if (mute && !busy) last_strobe = -1;
            if (smp_strobe) begin
                if (busy && last_strobe >= 0 && exp_period.size() > 0)
                    chk("period", cyc - last_strobe, exp_period.pop_front());
                last_strobe = cyc;
                if (mute) win_strobes++;
            end
            if (src_select != prev_src || rate_active != prev_rate) begin
                if (exp_sw.size() == 0) begin
                    chk("unexpected_switch", int'(src_select) * 8 + int'(rate_active), -1);
                end else begin
                    mon_e = exp_sw.pop_front();
                    chk("sw_src", int'(src_select), mon_e.src);
                    chk("sw_rate", int'(rate_active), mon_e.rate);
                    chk("sw_strobes", win_strobes, mon_e.nstr);
                    chk("sw_count", int'(smp_count), mon_e.cnt);
                    chk("sw_busy", int'(busy), 1);
                end
            end
            if (prev_mute && !mute) begin
                if (exp_mute.size() == 0) chk("unexpected_unmute", win_strobes, -1);
                else chk("mute_strobes", win_strobes, exp_mute.pop_front());
                win_strobes = 0;
            end
            prev_src  = src_select;
            prev_rate = rate_active;
            prev_mute = mute;
        end
    end

    initial begin
        int n;
        int seen;
        rst_n      = 1'b0;
        run        = 1'b0;
        req_select = 2'd3;
        req_rate   = 3'd1;
        repeat (3) @(negedge clk);
        chk("rst_mute", int'(mute), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_src", int'(src_select), 0);
        chk("rst_rate", int'(rate_active), 1);
        chk("rst_count", int'(smp_count), 0);
        chk("rst_strobe", int'(smp_strobe), 0);

        // Start-up: IDLE -> SETTLE with triangle at 48k, unmute after 8 strobes
        push_sw(3, 1, 0, 0);
        exp_mute.push_back(8);
        push_periods(1024, 7);
        rst_n = 1'b1;
        @(negedge clk);
        run = 1'b1;
        wait_mute_fall("s1_unmute", 12000);
        chk("s1_src", int'(src_select), 3);
        chk("s1_busy", int'(busy), 0);

        // Source change in RUN: 4 strobes muted, switch, 8 strobes settle
        req_select = 2'd0;
        push_sw(0, 1, 4, 1);
        exp_mute.push_back(12);
        push_periods(1024, 4);
        push_periods(1025, 1);
        push_periods(1024, 7);
        @(negedge clk);
        chk("s2_mute_next", int'(mute), 1);
        chk("s2_busy_next", int'(busy), 1);
        wait_mute_fall("s2_unmute", 16000);
        chk("s2_busy_after", int'(busy), 0);

        // Rate change 48k -> 192k: period drops from 1024 to 256 across SWITCH
        req_rate = 3'd4;
        push_sw(0, 4, 4, 1);
        exp_mute.push_back(12);
        push_periods(1024, 4);
        push_periods(257, 1);
        push_periods(256, 7);
        @(negedge clk);
        chk("s3_mute_next", int'(mute), 1);
        wait_mute_fall("s3_unmute", 12000);
        chk("s3_rate", int'(rate_active), 4);

        // Request changed again during SETTLE: second SWITCH without a MUTE phase
        req_select = 2'd1;
        push_sw(1, 4, 4, 1);
        push_sw(2, 4, 12, 1);
        exp_mute.push_back(20);
        push_periods(256, 4);
        push_periods(257, 1);
        push_periods(256, 7);
        push_periods(257, 1);
        push_periods(256, 7);
        seen = 0;
        for (int i = 0; i < 3000 && seen == 0; i++) begin
            @(negedge clk);
            if (exp_sw.size() <= 1) seen = 1;
        end
        chk("s4_first_switch", seen, 1);
        req_select = 2'd2;
        wait_mute_fall("s4_unmute", 8000);
        chk("s4_src", int'(src_select), 2);

        // run dropped mid-MUTE: IDLE next clk, then resume into SETTLE
        req_select = 2'd3;
        exp_mute.push_back(10);
        push_periods(256, 2);
        n = 0;
        for (int i = 0; i < 2000 && n < 2; i++) begin
            @(negedge clk);
            if (smp_strobe) n++;
        end
        chk("s5_two_strobes", n, 2);
        run = 1'b0;
        @(negedge clk);
        chk("s5_idle_strobe", int'(smp_strobe), 0);
        chk("s5_idle_count", int'(smp_count), 0);
        chk("s5_idle_mute", int'(mute), 1);
        chk("s5_idle_busy", int'(busy), 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (smp_strobe) n++;
        end
        chk("s5_idle_quiet", n, 0);
        chk("s5_idle_count_hold", int'(smp_count), 0);
        push_sw(3, 4, 2, 0);
        push_periods(256, 7);
        run = 1'b1;
        wait_mute_fall("s5_unmute", 6000);
        chk("s5_src", int'(src_select), 3);

        // Asynchronous reset mid-count, then restart with reserved rate code 6
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_mute", int'(mute), 1);
        chk("s6_busy", int'(busy), 0);
        chk("s6_src", int'(src_select), 0);
        chk("s6_rate", int'(rate_active), 1);
        chk("s6_count", int'(smp_count), 0);
        chk("s6_strobe", int'(smp_strobe), 0);
        @(negedge clk);
        req_rate = 3'd6;
        push_sw(3, 6, 0, 0);
        exp_mute.push_back(8);
        push_periods(1024, 7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_mute_fall("s6_unmute", 12000);
        chk("s6_rate_after", int'(rate_active), 6);

        repeat (4) @(negedge clk);
        chk("sb_period_empty", exp_period.size(), 0);
        chk("sb_switch_empty", exp_sw.size(), 0);
        chk("sb_mute_empty", exp_mute.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
